npu_wb_mailbox: RTL
===================

Name: npu_wb_mailbox

Overview:
- Wishbone slave front-end of user_proj_npu. It sits between the Caravel Wishbone port and the NPU compute core.
- Writes from the management SoC become 32-bit command words. They are buffered in a command FIFO and streamed to the core over valid/ready.
- Core results return over valid/ready into a result FIFO, which the SoC pops by reading a register.
- A status register exposes FIFO levels and sticky error flags.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base address; bits [31:4] must match for the block to respond.
- CMD_DEPTH, 8, command FIFO entries; power of two, 2..16.
- RES_DEPTH, 8, result FIFO entries; power of two, 2..16.

Ports:
- wb_clk_i  in  1  sole clock; all logic on rising edge.
- wb_rst_ni  in  1  synchronous active-low reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- cmd_valid_o  out  1  command word available to core.
- cmd_data_o  out  32  command word.
- cmd_ready_i  in  1  core accepts command.
- res_valid_i  in  1  core presents result.
- res_data_i  in  32  result word.
- res_ready_o  out  1  result FIFO can accept.
- core_busy_i  in  1  core busy, mirrored into STATUS.
- irq_o  out  1  result-available interrupt (see Optional Feature).

Behaviour:
- Reset (wb_rst_ni=0 at clock edge):
  - wbs_ack_o=0, wbs_dat_o=0, cmd_valid_o=0, res_ready_o=0, irq_o=0.
  - Both FIFOs empty; sticky flags and CTRL cleared.
  - Reset mid-transaction aborts it: no ack is issued for that request.
- Request and hit:
  - req = cyc & stb & !ack.
  - hit = req & (adr[31:4]==BASE_ADDR[31:4]). Misses are never acked.
- Ack timing:
  - ack is registered and asserts exactly one cycle after hit, for one cycle.
  - wbs_dat_o is registered with ack and returns 0 when ack=0.
  - Back-to-back accesses: one ack per two cycles at most.
- Register map, selected by adr[3:2]:
  - 0x0 CMD, write only:
    - A write on the hit cycle pushes wbs_dat_i; wbs_sel_i is ignored.
    - If the FIFO is full, the word is dropped, the access is still acked, and OVF is set.
    - A pop in the same cycle does not make room.
    - Reads return 0.
  - 0x4 STATUS:
    - Read layout:
      - [4:0] cmd_count
      - [12:8] res_count
      - [16] cmd_full
      - [17] res_empty
      - [18] OVF
      - [19] UDF
      - [20] core_busy_i
      - other bits 0
    - Write: W1C on bits 18/19 when sel[2]=1.
  - 0x8 RESULT, read:
    - Pops the head and returns it.
    - If empty, returns 0 and sets UDF.
    - Writes are ignored and acked.
  - 0xC CTRL:
    - bit0 SOFT_CLR: write 1 with sel[0] flushes both FIFOs and clears OVF/UDF on the next edge. It is self-clearing and reads 0.
    - bit1 IRQ_EN: read/write.
- Command stream:
  - cmd_valid_o = cmd FIFO not empty.
  - cmd_data_o = FIFO head.
  - Pop occurs when valid & cmd_ready_i.
  - Push-to-valid latency is 1 cycle after the hit cycle.
- Result stream:
  - res_ready_o = result FIFO not full.
  - Push occurs when res_valid_i & res_ready_o.
  - A result pushed at cycle t is visible in res_count at t+1.
- Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged and both operations take effect.
- Count width: cmd_count and res_count reach DEPTH exactly (e.g. 8 = 5'b01000) and do not wrap.
- Pointers wrap modulo DEPTH.
- SOFT_CLR coinciding with a push or pop: the clear wins.

Optional Feature:
- Macro: NPU_MBOX_IRQ_EN.
- Defined:
  - irq_o = IRQ_EN & !res_empty, registered, 1-cycle latency.
  - IRQ_EN is read/write.
- Undefined:
  - irq_o tied 0.
  - CTRL bit1 is write-ignored and reads 0.

Decomposition:
- Package npu_mbox_pkg:
  - register offsets: REG_CMD=2'd0, REG_STATUS=2'd1, REG_RESULT=2'd2, REG_CTRL=2'd3.
  - STATUS bit positions.
  - CTRL bit positions.
- Sub-module npu_sync_fifo:
  - parameters WIDTH and DEPTH.
  - synchronous active-low reset.
  - synchronous clear.
  - push, pop, full, empty, count.
  - instantiated twice.

Test Plan:
- Reset, then read STATUS → ack 1 cycle after stb, data 32'h0002_0000 (res_empty=1).
- Write CMD 32'hDEAD_BEEF with cmd_ready_i=0 → cmd_valid_o=1 with data DEADBEEF; STATUS cmd_count=1; raise ready → valid drops next cycle.
- Fill 8 CMD writes, then a 9th write 32'h1234 → acked, dropped, STATUS=cmd_count 8, full=1, OVF=1; W1C write 32'h0004_0000 with sel=4'b0100 → OVF cleared.
- Core pushes 32'hA5A5_0001 and 32'hA5A5_0002 → two RESULT reads return them in order; a third read returns 0 and sets UDF.
- Queue 3 commands and 2 results, write CTRL 1 → next cycle STATUS counts 0, cmd_valid_o=0, flags clear.
- With NPU_MBOX_IRQ_EN: set IRQ_EN, core pushes one result → irq_o=1 one cycle later; RESULT read → irq_o=0. Access to address 0x3000_0010 → never acked.

Source files
------------

// File: rtl/npu_mbox_pkg.sv
// Shared definitions for the NPU Wishbone mailbox: register offsets, STATUS/CTRL
// bit positions and the STATUS word packer.
package npu_mbox_pkg;

  typedef enum logic [1:0] {
    REG_CMD    = 2'd0,
    REG_STATUS = 2'd1,
    REG_RESULT = 2'd2,
    REG_CTRL   = 2'd3
  } reg_sel_e;

  localparam int unsigned ST_CMD_CNT_LSB = 0;
  localparam int unsigned ST_RES_CNT_LSB = 8;
  localparam int unsigned ST_CMD_FULL    = 16;
  localparam int unsigned ST_RES_EMPTY   = 17;
  localparam int unsigned ST_OVF         = 18;
  localparam int unsigned ST_UDF         = 19;
  localparam int unsigned ST_CORE_BUSY   = 20;

  localparam int unsigned CTRL_SOFT_CLR  = 0;
  localparam int unsigned CTRL_IRQ_EN    = 1;

  function automatic logic [31:0] pack_status(
    input logic [4:0] cmd_count,
    input logic [4:0] res_count,
    input logic       cmd_full,
    input logic       res_empty,
    input logic       ovf,
    input logic       udf,
    input logic       core_busy
  );
    logic [31:0] w;
    w = '0;
    w[ST_CMD_CNT_LSB +: 5] = cmd_count;
    w[ST_RES_CNT_LSB +: 5] = res_count;
    w[ST_CMD_FULL]         = cmd_full;
    w[ST_RES_EMPTY]        = res_empty;
    w[ST_OVF]              = ovf;
    w[ST_UDF]              = udf;
    w[ST_CORE_BUSY]        = core_busy;
    return w;
  endfunction

endpackage

// File: rtl/npu_wb_mailbox_if.sv
// Wishbone slave bus bundle for npu_wb_mailbox; signal names follow the
// slave-side Caravel port names.
interface npu_wb_mailbox_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/npu_sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset and synchronous clear.
// Count saturates at DEPTH; pointers wrap modulo DEPTH (DEPTH a power of two).
module npu_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Push is qualified on the pre-pop fullness, so a pop never frees room for
  // a push in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/npu_wb_mailbox.sv
// Wishbone slave mailbox for the NPU: CMD/STATUS/RESULT/CTRL registers over two
// FIFOs. Optional result interrupt enabled by defining NPU_MBOX_IRQ_EN.
module npu_wb_mailbox
  import npu_mbox_pkg::*;
#(
  parameter logic [31:0]  BASE_ADDR = 32'h3000_0000,
  parameter int unsigned  CMD_DEPTH = 8,
  parameter int unsigned  RES_DEPTH = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  npu_wb_mailbox_if.slave   wbs,
  output logic              cmd_valid_o,
  output logic [31:0]       cmd_data_o,
  input  logic              cmd_ready_i,
  input  logic              res_valid_i,
  input  logic [31:0]       res_data_i,
  output logic              res_ready_o,
  input  logic              core_busy_i,
  output logic              irq_o
);

  localparam int unsigned CCW = $clog2(CMD_DEPTH) + 1;
  localparam int unsigned RCW = $clog2(RES_DEPTH) + 1;

  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  logic        alive_q;
  logic        irq_en;

  logic        req, hit, wr_hit, rd_hit;
  reg_sel_e    reg_sel;
  logic        soft_clr;

  logic        cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CCW-1:0] cmd_count;
  logic        res_push, res_pop, res_full, res_empty;
  logic [RCW-1:0] res_count;
  logic [31:0] res_head;
  logic [31:0] status_word, ctrl_word;

  logic        unused_bits;
  assign unused_bits = ^{wbs.wbs_sel_i[3], wbs.wbs_sel_i[1], wbs.wbs_adr_i[1:0]};

  assign req     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
  assign hit     = req & (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_hit  = hit & wbs.wbs_we_i;
  assign rd_hit  = hit & ~wbs.wbs_we_i;
  assign reg_sel = reg_sel_e'(wbs.wbs_adr_i[3:2]);

  assign soft_clr = wr_hit & (reg_sel == REG_CTRL) & wbs.wbs_sel_i[0]
                  & wbs.wbs_dat_i[CTRL_SOFT_CLR];

  assign cmd_push    = wr_hit & (reg_sel == REG_CMD);
  assign cmd_pop     = cmd_valid_o & cmd_ready_i;
  assign cmd_valid_o = ~cmd_empty;

  // res_ready_o stays low until the first cycle out of reset.
  assign res_ready_o = alive_q & ~res_full;
  assign res_push    = res_valid_i & res_ready_o;
  assign res_pop     = rd_hit & (reg_sel == REG_RESULT);

  npu_sync_fifo #(.WIDTH(32), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .clr_i   (soft_clr),
    .push_i  (cmd_push),
    .data_i  (wbs.wbs_dat_i),
    .pop_i   (cmd_pop),
    .data_o  (cmd_data_o),
    .full_o  (cmd_full),
    .empty_o (cmd_empty),
    .count_o (cmd_count)
  );

  npu_sync_fifo #(.WIDTH(32), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .clr_i   (soft_clr),
    .push_i  (res_push),
    .data_i  (res_data_i),
    .pop_i   (res_pop),
    .data_o  (res_head),
    .full_o  (res_full),
    .empty_o (res_empty),
    .count_o (res_count)
  );

  assign status_word = pack_status(5'(cmd_count), 5'(res_count), cmd_full,
                                   res_empty, ovf_q, udf_q, core_busy_i);

  always_comb begin
    ctrl_word              = '0;
    ctrl_word[CTRL_IRQ_EN] = irq_en;
  end

  always_comb begin
    ack_d   = hit;
    rdata_d = '0;
    if (rd_hit) begin
      case (reg_sel)
        REG_STATUS: rdata_d = status_word;
        REG_RESULT: rdata_d = res_empty ? '0 : res_head;
        REG_CTRL:   rdata_d = ctrl_word;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (soft_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (cmd_push && cmd_full) ovf_d = 1'b1;
      if (res_pop && res_empty) udf_d = 1'b1;
      if (wr_hit && (reg_sel == REG_STATUS) && wbs.wbs_sel_i[2]) begin
        if (wbs.wbs_dat_i[ST_OVF]) ovf_d = 1'b0;
        if (wbs.wbs_dat_i[ST_UDF]) udf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      alive_q <= 1'b1;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = rdata_q;

`ifdef NPU_MBOX_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_hit && (reg_sel == REG_CTRL) && wbs.wbs_sel_i[0])
      irq_en_d = wbs.wbs_dat_i[CTRL_IRQ_EN];
    irq_d = irq_en_q & ~res_empty;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en = irq_en_q;
  assign irq_o  = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif

endmodule
